// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul run sequencer: FSM encoding, display depth
// and the C result bank bases in the display address space.
package matmul_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SINGLE,
        S_SYS3,
        S_SYS2,
        S_DISPLAY,
        S_FINISH,
        S_ERR
    } state_t;

    localparam int         DISP_COUNT    = 12;
    localparam logic [3:0] DISP_LAST     = 4'(DISP_COUNT - 1);
    localparam logic [3:0] C_BASE_SINGLE = 4'd0;
    localparam logic [3:0] C_BASE_SYS3   = 4'd4;
    localparam logic [3:0] C_BASE_SYS2   = 4'd8;

    // Successor of each compute phase once its completion is seen.
    function automatic state_t next_phase(input state_t s);
        case (s)
            S_INIT:   return S_SINGLE;
            S_SINGLE: return S_SYS3;
            S_SYS3:   return S_SYS2;
            S_SYS2:   return S_DISPLAY;
            default:  return S_ERR;
        endcase
    endfunction

endpackage

// File: rtl/matmul_sequencer_disp_scanner.sv
// Steps the display address 0..DISP_LAST while en is high, holding each value
// for 'hold' cycles; 'last' marks the final cycle of the final address.
module disp_scanner
    import matmul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] hold,
    output logic [3:0]  sel,
    output logic        valid,
    output logic        last
);

    logic [15:0] hold_cnt;
    logic        hold_end;

    assign hold_end = ({1'b0, hold_cnt} + 17'd1) >= {1'b0, hold};
    assign last     = valid && (sel == DISP_LAST) && hold_end;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            valid    <= 1'b0;
            sel      <= 4'd0;
            hold_cnt <= '0;
        end else if (!valid) begin
            valid    <= 1'b1;
            sel      <= 4'd0;
            hold_cnt <= '0;
        end else if (hold_end) begin
            hold_cnt <= '0;
            // Drop valid in the same edge the FSM leaves DISPLAY, so sel never passes 11.
            if (sel == DISP_LAST) begin
                valid <= 1'b0;
                sel   <= 4'd0;
            end else begin
                sel <= sel + 4'd1;
            end
        end else begin
            hold_cnt <= hold_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Run sequencer: memory capture, three engine phases with per-phase timeout,
// then a display scan of the result banks and a one-cycle done pulse.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int TIMEOUT   = 64,
    parameter int DISP_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       done_save_to_external,
    input  logic       single_done_i,
    input  logic       sys3_done_i,
    input  logic       sys2_done_i,
    output logic       init_valid_i,
    output logic       single_valid_i,
    output logic       sys3_valid_i,
    output logic       sys2_valid_i,
    output logic [3:0] select_from_display,
    output logic       disp_valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      nxt;
    logic [15:0] phase_cnt;
    logic        phase_done;
    logic        scan_en;
    logic        scan_last;

    always_comb begin
        phase_done = 1'b0;
        case (state)
            S_INIT:   phase_done = done_save_to_external;
            S_SINGLE: phase_done = single_done_i;
            S_SYS3:   phase_done = sys3_done_i;
            S_SYS2:   phase_done = sys2_done_i;
            default:  phase_done = 1'b0;
        endcase
    end

    assign nxt = next_phase(state);
    // Start the scanner on the edge that enters DISPLAY so its outputs line up with the state.
    assign scan_en = (state == S_DISPLAY) || ((state == S_SYS2) && sys2_done_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            phase_cnt      <= '0;
            init_valid_i   <= 1'b0;
            single_valid_i <= 1'b0;
            sys3_valid_i   <= 1'b0;
            sys2_valid_i   <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state        <= S_INIT;
                        phase_cnt    <= '0;
                        init_valid_i <= 1'b1;
                        busy_o       <= 1'b1;
                    end
                end
                S_INIT, S_SINGLE, S_SYS3, S_SYS2: begin
                    if (phase_done) begin
                        state          <= nxt;
                        phase_cnt      <= '0;
                        init_valid_i   <= 1'b0;
                        single_valid_i <= (nxt == S_SINGLE);
                        sys3_valid_i   <= (nxt == S_SYS3);
                        sys2_valid_i   <= (nxt == S_SYS2);
                    end else if (phase_cnt == TO_LAST) begin
                        state          <= S_ERR;
                        init_valid_i   <= 1'b0;
                        single_valid_i <= 1'b0;
                        sys3_valid_i   <= 1'b0;
                        sys2_valid_i   <= 1'b0;
                        busy_o         <= 1'b0;
                        error_o        <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                S_DISPLAY: begin
                    if (scan_last) begin
                        state  <= S_FINISH;
                        done_o <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

    disp_scanner u_scan (
        .clk   (clk),
        .rst   (rst),
        .en    (scan_en),
        .hold  (16'(DISP_HOLD)),
        .sel   (select_from_display),
        .valid (disp_valid_o),
        .last  (scan_last)
    );

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64, giving the maximum cycles allowed per compute phase before an error.
REQ-002 The block SHALL have parameter DISP_HOLD, default 4, giving the cycles each display select value is held.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit: a one-cycle pulse that starts a full run.
REQ-006 The block SHALL have port done_save_to_external, input, 1 bit: the memory's acknowledgement that the A and B matrices are captured.
REQ-007 The block SHALL have ports single_done_i, sys3_done_i and sys2_done_i, input, 1 bit each: engine completion pulses.
REQ-008 The block SHALL have port init_valid_i, output, 1 bit: drives the memory capture of the A and B matrices.
REQ-009 The block SHALL have ports single_valid_i, sys3_valid_i and sys2_valid_i, output, 1 bit each: the engine and memory C-write enables.
REQ-010 The block SHALL have port select_from_display, output, 4 bits: the memory display address, 0 to 11.
REQ-011 The block SHALL have port disp_valid_o, output, 1 bit: high while select_from_display is meaningful.
REQ-012 The block SHALL have ports busy_o, done_o and error_o, output, 1 bit each: status, with done_o a one-cycle pulse.
REQ-013 All outputs SHALL be registered.

Function
REQ-014 The FSM SHALL have the states IDLE, INIT, SINGLE, SYS3, SYS2, DISPLAY, FINISH and ERR.
REQ-015 In IDLE, start_i=1 SHALL move the FSM to INIT on the next edge; start_i in any other state SHALL be ignored.
REQ-016 In INIT, init_valid_i SHALL be 1 until done_save_to_external is sampled 1, after which the FSM goes to SINGLE and init_valid_i is 0 on the following cycle.
REQ-017 In SINGLE, single_valid_i SHALL be 1, and sampling single_done_i=1 SHALL advance the FSM to SYS3; SYS3 SHALL do the same using sys3_valid_i and sys3_done_i, advancing to SYS2.
REQ-018 In SYS2, sys2_valid_i SHALL be 1, and sampling sys2_done_i=1 SHALL advance the FSM to DISPLAY.
REQ-019 At most one of init_valid_i, single_valid_i, sys3_valid_i and sys2_valid_i SHALL be 1 in any cycle.
REQ-020 There SHALL be no idle cycle between phases: the next valid rises in the same cycle the previous one falls.
REQ-021 Done pulses from engines that are not the active phase SHALL be ignored.
REQ-022 A 16-bit phase counter SHALL clear on every phase entry and increment each cycle in INIT, SINGLE, SYS3 and SYS2.
REQ-023 If the phase counter reaches TIMEOUT-1 without the expected done, the FSM SHALL go to ERR; a done sampled in that same cycle SHALL win over the timeout.
REQ-024 In DISPLAY, disp_valid_o SHALL be 1 and select_from_display SHALL step 0,1,...,11, holding each value DISP_HOLD cycles, using a hold counter and the 4-bit index.
REQ-025 After index 11 has been held for DISP_HOLD cycles, the FSM SHALL go to FINISH; the index SHALL never exceed 11.
REQ-026 FINISH SHALL last exactly one cycle with done_o=1, and SHALL return to IDLE.
REQ-027 ERR SHALL hold error_o=1 with all valids 0 and SHALL exit only on rst.
REQ-028 busy_o SHALL be 1 in every state except IDLE and ERR.

Reset
REQ-029 rst=1 on any edge SHALL force IDLE and clear all counters, including when it occurs mid-phase.
REQ-030 After reset, all outputs SHALL be 0 and select_from_display SHALL be 4'd0.
REQ-031 rst SHALL take priority over start_i and over every done input.

Structure
REQ-032 The state encoding, the display-count constant (12) and the C bank bases (single 0, sys3 4, sys2 8) SHALL be defined in the shared package matmul_pkg.
REQ-033 The display scan SHALL be a separate sub-module, disp_scanner, with inputs en and hold and outputs sel, valid and last.
REQ-034 The implementation SHALL be 120-250 lines of RTL.

Verification (TIMEOUT=16, DISP_HOLD=2)
REQ-035 Nominal run: pulse start_i, ack 3 cycles later, then each engine done 5 cycles after its valid rises -> the valids go high in order with no overlap, sel runs 0..11 in 24 cycles, and done_o pulses exactly once.
REQ-036 Timeout: sys3_done_i is never asserted -> error_o=1 exactly 16 cycles after SYS3 entry, all valids are 0, and a later start_i is ignored.
REQ-037 Stray done: sys2_done_i is pulsed during SINGLE -> the FSM stays in SINGLE and sys2_valid_i stays 0.
REQ-038 Mid-run reset: rst is asserted for 1 cycle during SYS2 -> the next cycle shows IDLE with all outputs 0, and a new start_i completes normally.
REQ-039 Boundary: single_done_i arrives in the same cycle the counter reaches 15 -> the FSM advances to SYS3 with no error; start_i pulsed during DISPLAY -> no effect.
